// File: rtl/spi_lens_pkg.sv
// spi_lens_pkg: shared state encoding, SPI mode constants and
// divider helper for the lens-port SPI master.
package spi_lens_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      WAIT,
      ARMED
   } state_e;

   // Mode encoding is {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic logic [31:0] eff_div(input logic [31:0] div);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/spi_lens_master_clk_gen.sv
// spi_clk_gen: half-period tick counter; counts SCLK half periods
// and reports the index of the half period that just completed.
module spi_clk_gen #(
   parameter int DIV_W = 16,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [DIV_W-1:0] half_i,
   output logic             tick_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign tick_o = en_i && (cnt_q == half_i - DIV_W'(1));
   assign idx_o  = idx_q;

   // Held at zero while disabled, so every enable rise restarts cleanly
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en_i) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (tick_o) begin
         cnt_d = '0;
         idx_d = idx_q + IDX_W'(1);
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/spi_lens_master.sv
// spi_lens_master: SPI master transaction engine for the lens port
// with programmable divider, CPOL/CPHA, word width and CS count.
module spi_lens_master
   import spi_lens_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 1,
   parameter int DIV_W  = 16,
   parameter int WAIT_W = 16,
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_tx,
   input  logic [CS_W-1:0]   cmd_cs,
   input  logic              cmd_last,
   input  logic [WAIT_W-1:0] cmd_wait,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              cpol,
   input  logic              cpha,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [NUM_CS-1:0] spi_cs_n
);

   localparam int IDX_W = $clog2(2 * DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * DATA_W);
   localparam logic [IDX_W-1:0] LAST_M1  = IDX_W'(2 * DATA_W - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rxsh_q, rxsh_d;
   logic [DATA_W-1:0]   rxd_q, rxd_d;
   logic                rxv_q, rxv_d;
   logic                mosi_q, mosi_d;
   logic                sclk_q, sclk_d;
   logic [NUM_CS-1:0]   csn_q, csn_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   logic                last_q, last_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic [DIV_W-1:0]    h_q, h_d;

   logic                tick;
   logic [IDX_W-1:0]    idx;
   logic                gen_en;
   logic                sample;
   logic                fin;
   logic [NUM_CS-1:0]   cs_sel;

   assign busy      = (state_q != IDLE);
   assign cmd_ready = (state_q == IDLE) || (state_q == ARMED);
   assign gen_en    = (state_q == SETUP) || (state_q == SHIFT);

   assign rx_data  = rxd_q;
   assign rx_valid = rxv_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = csn_q;

   spi_clk_gen #(
      .DIV_W (DIV_W),
      .IDX_W (IDX_W)
   ) u_clk_gen (
      .clk    (clk),
      .rst    (rst),
      .en_i   (gen_en),
      .half_i (h_q),
      .tick_o (tick),
      .idx_o  (idx)
   );

   // Out-of-range index selects nothing; the word still shifts
   always_comb begin
      cs_sel = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cmd_cs == CS_W'(i)) cs_sel[i] = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rxsh_d  = rxsh_q;
      rxd_d   = rxd_q;
      rxv_d   = 1'b0;
      mosi_d  = mosi_q;
      sclk_d  = sclk_q;
      csn_d   = csn_q;
      wait_d  = wait_q;
      wcnt_d  = wcnt_q;
      last_d  = last_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      h_d     = h_q;
      sample  = 1'b0;
      fin     = 1'b0;

      unique case (state_q)
         IDLE: begin
            sclk_d = cpol;
            csn_d  = '1;
         end
         ARMED: begin
            sclk_d = cpol_q;
         end
         SETUP, SHIFT: begin
            if (tick) begin
               if (idx == LAST_IDX) begin
                  rxd_d = rxsh_q;
                  rxv_d = 1'b1;
                  if (wait_q != '0) begin
                     state_d = WAIT;
                     wcnt_d  = wait_q;
                  end else begin
                     fin = 1'b1;
                  end
               end else begin
                  state_d = SHIFT;
                  sclk_d  = ~sclk_q;
                  // Even idx is a leading edge; cpha swaps sample/shift
                  sample  = ~idx[0] ^ cpha_q;
                  if (sample) begin
                     rxsh_d = {rxsh_q[DATA_W-2:0], spi_miso};
                  end else if (idx != LAST_M1) begin
                     mosi_d = tx_q[DATA_W-1];
                     tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
         end
         WAIT: begin
            wcnt_d = wcnt_q - WAIT_W'(1);
            if (wcnt_q == WAIT_W'(1)) fin = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (fin) begin
         state_d = last_q ? IDLE : ARMED;
         sclk_d  = cpol_q;
      end

      if (cmd_valid && cmd_ready) begin
         state_d = SETUP;
         wait_d  = cmd_wait;
         last_d  = cmd_last;
         cpol_d  = cpol;
         cpha_d  = cpha;
         h_d     = DIV_W'(eff_div(32'(clk_div)));
         sclk_d  = cpol;
         if (cpha) begin
            tx_d = cmd_tx;
         end else begin
            mosi_d = cmd_tx[DATA_W-1];
            tx_d   = {cmd_tx[DATA_W-2:0], 1'b0};
         end
         if (state_q == IDLE) csn_d = cs_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rxsh_q  <= '0;
         rxd_q   <= '0;
         rxv_q   <= 1'b0;
         mosi_q  <= 1'b0;
         sclk_q  <= 1'b0;
         csn_q   <= '1;
         wait_q  <= '0;
         wcnt_q  <= '0;
         last_q  <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         h_q     <= DIV_W'(1);
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rxsh_q  <= rxsh_d;
         rxd_q   <= rxd_d;
         rxv_q   <= rxv_d;
         mosi_q  <= mosi_d;
         sclk_q  <= sclk_d;
         csn_q   <= csn_d;
         wait_q  <= wait_d;
         wcnt_q  <= wcnt_d;
         last_q  <= last_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         h_q     <= h_d;
      end
   end

endmodule

// File: tb/tb_spi_lens_master.sv
// tb_spi_lens_master: directed bench for the lens SPI master with
// an in-loop slave model and cycle-accurate timing checks.
module tb_spi_lens_master;
   import spi_lens_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_tx = '0;
   logic [0:0]  cmd_cs = '0;
   logic        cmd_last = 1'b0;
   logic [15:0] cmd_wait = '0;
   logic [15:0] clk_div = '0;
   logic        cpol = 1'b0;
   logic        cpha = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        busy;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic [1:0]  spi_cs_n;

   logic        loop_en = 1'b0;
   logic        slv_miso = 1'b0;

   int          n_tests = 0;
   int          n_fail = 0;

   int          rxv_cyc, rdy_cyc, rises, cs_bad, busy_bad, rxv_cnt;
   logic [7:0]  rx_got, mosi_cap, s_sh;

   assign spi_miso = loop_en ? spi_mosi : slv_miso;

   always #5 clk = ~clk;

   spi_lens_master #(
      .DATA_W (8),
      .NUM_CS (2),
      .DIV_W  (16),
      .WAIT_W (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_tx    (cmd_tx),
      .cmd_cs    (cmd_cs),
      .cmd_last  (cmd_last),
      .cmd_wait  (cmd_wait),
      .clk_div   (clk_div),
      .cpol      (cpol),
      .cpha      (cpha),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .spi_cs_n  (spi_cs_n)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One word: present at a negedge, then watch cycles 1..ready
   task automatic xfer(input logic [7:0] tx, input int cs,
                       input logic last, input int wt, input int dv,
                       input logic pol, input logic pha,
                       input logic [7:0] resp, input logic lp,
                       input logic churn);
      logic [1:0] exp_cs;
      logic       sclk_prev;
      logic       lead;
      int         n;
      exp_cs   = (cs < 2) ? ~(2'b01 << cs) : 2'b11;
      loop_en  = lp;
      s_sh     = resp;
      if (!pha) begin
         slv_miso = resp[7];
         s_sh     = {resp[6:0], 1'b0};
      end
      mosi_cap = '0;
      rx_got   = '0;
      rxv_cyc  = -1;
      rdy_cyc  = -1;
      rises    = 0;
      cs_bad   = 0;
      busy_bad = 0;
      cmd_tx    = tx;
      cmd_cs    = cs[0:0];
      cmd_last  = last;
      cmd_wait  = wt[15:0];
      clk_div   = dv[15:0];
      cpol      = pol;
      cpha      = pha;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_tx    = ~tx;
      if (churn) begin
         cpol    = ~pol;
         clk_div = 16'd5;
      end
      sclk_prev = pol;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (spi_sclk !== sclk_prev) begin
            lead = (spi_sclk != pol);
            if (spi_sclk) rises++;
            if (lead ^ pha) begin
               mosi_cap = {mosi_cap[6:0], spi_mosi};
            end else begin
               slv_miso = s_sh[7];
               s_sh     = {s_sh[6:0], 1'b0};
            end
            sclk_prev = spi_sclk;
         end
         if (rx_valid) begin
            rxv_cnt++;
            if (rxv_cyc < 0) begin
               rxv_cyc = c;
               rx_got  = rx_data;
            end
         end
         if (spi_cs_n !== exp_cs) cs_bad++;
         if (cmd_ready) begin
            rdy_cyc = c;
            break;
         end
         if (!busy) busy_bad++;
      end
      if (rdy_cyc < 0) check("ready_timeout", 32'd0, 32'd1);
   endtask

   logic [1:0] modes [4];
   logic [7:0] mw_tx [3];
   logic [7:0] mw_rs [3];

   initial begin
      #200_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      modes = '{MODE0, MODE1, MODE2, MODE3};
      mw_tx = '{8'h11, 8'h22, 8'h33};
      mw_rs = '{8'h5A, 8'hC3, 8'h0F};

      repeat (3) @(negedge clk);
      check("rst_cs_n", 32'(spi_cs_n), 32'h3);
      check("rst_sclk", 32'(spi_sclk), 32'h0);
      check("rst_mosi", 32'(spi_mosi), 32'h0);
      check("rst_rxv", 32'(rx_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ready", 32'(cmd_ready), 32'h1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Mode 0 loopback, H=2
      xfer(8'hA5, 0, 1'b1, 0, 2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("lb_rxv_cyc", rxv_cyc, 35);
      check("lb_rx", 32'(rx_got), 32'hA5);
      check("lb_rises", rises, 8);
      check("lb_ready_cyc", rdy_cyc, 35);
      check("lb_cs_low", cs_bad, 0);
      check("lb_mosi", 32'(mosi_cap), 32'hA5);
      @(negedge clk);
      check("lb_cs_rel", 32'(spi_cs_n), 32'h3);

      // All modes against the slave model
      for (int m = 0; m < 4; m++) begin
         xfer(8'h81, 0, 1'b1, 0, 3, modes[m][1], modes[m][0],
              8'h3C, 1'b0, 1'b0);
         check("mode_mosi", 32'(mosi_cap), 32'h81);
         check("mode_rx", 32'(rx_got), 32'h3C);
         check("mode_rxv_cyc", rxv_cyc, 52);
         @(negedge clk);
         check("mode_sclk_idle", 32'(spi_sclk), 32'(modes[m][1]));
      end

      // Three-word transaction on CS 1
      rxv_cnt = 0;
      for (int w = 0; w < 3; w++) begin
         xfer(mw_tx[w], 1, (w == 2), 0, 2, 1'b0, 1'b0,
              mw_rs[w], 1'b0, 1'b0);
         check("mw_rx", 32'(rx_got), 32'(mw_rs[w]));
         check("mw_mosi", 32'(mosi_cap), 32'(mw_tx[w]));
         check("mw_cs", cs_bad, 0);
         check("mw_rxv_cyc", rxv_cyc, 35);
      end
      check("mw_pulses", rxv_cnt, 3);
      @(negedge clk);
      check("mw_cs_rel", 32'(spi_cs_n), 32'h3);

      // clk_div=0 acts as H=1, with a 10-cycle wait
      xfer(8'h6E, 0, 1'b1, 10, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("wt_rxv_cyc", rxv_cyc, 18);
      check("wt_ready_cyc", rdy_cyc, 28);
      check("wt_busy", busy_bad, 0);
      check("wt_rx", 32'(rx_got), 32'h6E);
      check("wt_cs_low", cs_bad, 0);
      @(negedge clk);
      check("wt_cs_rel", 32'(spi_cs_n), 32'h3);

      // Reset during SHIFT
      loop_en   = 1'b1;
      cmd_tx    = 8'hFF;
      cmd_cs    = 1'b0;
      cmd_last  = 1'b1;
      cmd_wait  = '0;
      clk_div   = 16'd2;
      cpol      = 1'b0;
      cpha      = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (11) @(negedge clk);
      check("mr_pre_busy", 32'(busy), 32'h1);
      check("mr_pre_cs", 32'(spi_cs_n), 32'h2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mr_cs_n", 32'(spi_cs_n), 32'h3);
      check("mr_sclk", 32'(spi_sclk), 32'h0);
      check("mr_mosi", 32'(spi_mosi), 32'h0);
      check("mr_rx_data", 32'(rx_data), 32'h0);
      check("mr_busy", 32'(busy), 32'h0);
      check("mr_ready", 32'(cmd_ready), 32'h1);
      rxv_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (rx_valid) rxv_cnt++;
      end
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (rx_valid) rxv_cnt++;
      end
      check("mr_no_rxv", rxv_cnt, 0);
      xfer(8'h3C, 0, 1'b1, 0, 2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("mr_fresh_rx", 32'(rx_got), 32'h3C);
      check("mr_fresh_cyc", rxv_cyc, 35);

      // Input churn after accept must not disturb the transfer
      @(negedge clk);
      xfer(8'h96, 0, 1'b1, 0, 2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("ch_rxv_cyc", rxv_cyc, 35);
      check("ch_rx", 32'(rx_got), 32'h96);
      check("ch_rises", rises, 8);
      check("ch_cs_low", cs_bad, 0);
      cpol = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_lens_master.md
# spi_lens_master

Parametrised SPI master transaction engine for the lens port. It replaces the fixed-rate, fixed-byte driver/controller pair with one block that has:
- a programmable SCLK divider;
- all four CPOL/CPHA modes;
- a configurable word width and chip-select count;
- an inter-word wait;
- chip select held low across multi-word transactions.

It sits between the host wire-in/command logic and the LENS_SPI_* pins, clocked directly by the board clock.

## Interface
Parameters:
- DATA_W, 8, bits per SPI word, MSB first.
- NUM_CS, 1, number of chip selects (≥1).
- DIV_W, 16, width of the half-period divider field.
- WAIT_W, 16, width of the post-word wait field.

Ports:
- clk  in  1  system clock. One clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high in IDLE or ARMED; transfer on cmd_valid && cmd_ready.
- cmd_tx  in  DATA_W  word to shift out.
- cmd_cs  in  max(1,$clog2(NUM_CS))  chip-select index. Used only when accepted from IDLE.
- cmd_last  in  1  release CS after this word.
- cmd_wait  in  WAIT_W  clk cycles to idle after the word, CS still asserted.
- clk_div  in  DIV_W  SCLK half-period H in clk cycles. Value 0 is treated as 1.
- cpol, cpha  in  1 each  SPI mode.
- rx_data  out  DATA_W  last received word, held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in every state except IDLE.
- spi_sclk  out  1  SPI clock.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in. Already synchronised upstream.
- spi_cs_n  out  NUM_CS  active-low chip selects; at most one low.

## Operation
- States: IDLE, SETUP, SHIFT, WAIT, ARMED.
- Latched at accept:
  - always: cmd_tx, cmd_wait, cmd_last, cpol, cpha, H;
  - in IDLE only: cmd_cs.
  - Input changes after accept are ignored until the next accept.
- cmd_cs ≥ NUM_CS: the command is accepted, no CS is asserted, and the word still shifts (rx is whatever spi_miso gives).
- IDLE → SETUP on accept. The selected spi_cs_n goes low, spi_sclk = cpol.
- ARMED → SETUP on accept. CS is already low.
- SETUP, H cycles:
  - cpha=0: MOSI already carries tx[DATA_W-1].
  - cpha=1: MOSI holds its previous value.
- SHIFT, 2·DATA_W half-periods of H cycles; spi_sclk toggles at each half-period boundary.
  - cpha=0: sample on the leading (odd) edges, shift MOSI on the trailing edges.
  - cpha=1: shift MOSI on the leading edges, sample on the trailing edges.
  - The final edge returns spi_sclk to cpol.
- End of SHIFT: rx_data loads and rx_valid pulses. Then go to WAIT if cmd_wait > 0; otherwise finish immediately.
- WAIT: count cmd_wait cycles.
- Finish:
  - cmd_last=1 → deassert all CS, go to IDLE.
  - cmd_last=0 → go to ARMED. CS stays low and spi_sclk = cpol.
- ARMED persists indefinitely until the next command.

## Timing
- Reset values:
  - state IDLE;
  - spi_cs_n all 1;
  - spi_sclk 0, spi_mosi 0;
  - rx_data 0, rx_valid 0;
  - busy 0, cmd_ready 1.
- In IDLE, spi_sclk follows the current cpol input, registered with one cycle of delay.
- Accept edge = cycle 0. CS is low from cycle 1.
- First SCLK edge at cycle H+1.
- rx_valid is high in cycle H·(2·DATA_W+1)+1.
- cmd_ready returns:
  - cmd_wait=0: in the same cycle as rx_valid;
  - cmd_wait=W: W cycles later.
- Back-to-back: a command presented while cmd_ready is high is accepted that cycle. No bubble is added beyond the SETUP period.
- Reset asserted mid-transfer: outputs go to their reset values immediately (asynchronously). There is no partial rx_valid.

## Structure
- Package spi_lens_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, WAIT, ARMED);
  - mode constants MODE0..MODE3;
  - the rule that clk_div = 0 is treated as 1, as a function.
- Sub-module spi_clk_gen: a half-period tick counter. Inputs: clk, rst, enable, H. Outputs: a tick pulse and an edge index. It restarts on enable rise.
- The main FSM, shift registers and wait counter live in spi_lens_master.

## Test plan
- Mode 0 loopback: DATA_W=8, clk_div=2, cmd_tx=0xA5, miso tied to mosi, cmd_last=1, wait=0. Required:
  - rx_data=0xA5 and rx_valid in cycle 35;
  - 8 SCLK rising edges;
  - CS low cycles 1–35, high afterwards.
- All modes vs a slave model returning 0x3C, clk_div=3, tx=0x81:
  - MOSI is 0x81 MSB first and rx_data=0x3C in all four modes;
  - SCLK idles at cpol.
- Multi-word transaction: tx=0x11 (last=0), then 0x22 (last=0), then 0x33 (last=1), cs=1, NUM_CS=2:
  - spi_cs_n[1] stays low across all three words; spi_cs_n[0] stays high;
  - three rx_valid pulses;
  - CS releases after the third word.
- Wait and divider edge cases: clk_div=0 with cmd_wait=10. Required:
  - behaves as H=1, with rx_valid in cycle 18;
  - cmd_ready returns 10 cycles after rx_valid;
  - busy stays high throughout.
- Reset mid-SHIFT: assert rst at cycle 12 of a clk_div=2 transfer. Required:
  - all outputs at their reset values in that cycle;
  - no rx_valid;
  - a fresh command after reset completes normally.
- Input churn: change cpol and clk_div during SHIFT. The transfer timing is unaffected.
